// File: rtl/ofs_plat_host_chan_rd_throttle_if.sv
// ofs_plat_host_chan_rd_throttle_if: AFU c0 Tx request in (afu_rd_*), FIU c0 Tx request out (fiu_rd_*), FIU almost-full and read-line return; slave=throttle, master=environment
interface ofs_plat_host_chan_rd_throttle_if #(
  parameter int HDR_W = 128
);
  logic             afu_rd_valid;
  logic [1:0]       afu_rd_cl_len;
  logic [HDR_W-1:0] afu_rd_hdr;
  logic             afu_rd_ready;
  logic             fiu_rd_valid;
  logic [1:0]       fiu_rd_cl_len;
  logic [HDR_W-1:0] fiu_rd_hdr;
  logic             fiu_almost_full;
  logic             fiu_rsp_valid;
  modport slave (
    input  afu_rd_valid, afu_rd_cl_len, afu_rd_hdr, fiu_almost_full, fiu_rsp_valid,
    output afu_rd_ready, fiu_rd_valid, fiu_rd_cl_len, fiu_rd_hdr
  );
  modport master (
    output afu_rd_valid, afu_rd_cl_len, afu_rd_hdr, fiu_almost_full, fiu_rsp_valid,
    input  afu_rd_ready, fiu_rd_valid, fiu_rd_cl_len, fiu_rd_hdr
  );
endinterface

// File: rtl/ofs_plat_host_chan_rd_throttle.sv
// ofs_plat_host_chan_rd_throttle: c0 Tx read throttle with line budget, almost-full gating and drain handshake; ports clk, reset, ch (request/response bus), drain_req/drain_ack, outstanding, sticky err_illegal_len/err_underflow
module ofs_plat_host_chan_rd_throttle #(
  parameter int MAX_OUTSTANDING_LINES = 256,
  parameter int HDR_W = 128,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING_LINES + 1)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  ofs_plat_host_chan_rd_throttle_if.slave      ch,
  input  logic                                 drain_req,
  output logic                                 drain_ack,
  output logic [CNT_W-1:0]                     outstanding,
  output logic                                 err_illegal_len,
  output logic                                 err_underflow
);
  typedef enum logic [1:0] {RUN, DRAINING, DRAINED} state_t;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_OUTSTANDING_LINES - 4);
  state_t state, state_nx;
  logic accept, illegal, legal, dec;
  logic [CNT_W-1:0] lines, outstanding_nx;
  always_comb begin
    ch.afu_rd_ready = (state == RUN) && !ch.fiu_almost_full && (outstanding <= LIMIT);
    accept = ch.afu_rd_valid && ch.afu_rd_ready;
    illegal = accept && (ch.afu_rd_cl_len == 2'd2);
    legal = accept && !illegal;
    lines = ch.afu_rd_cl_len == 2'd0 ? CNT_W'(1) : ch.afu_rd_cl_len == 2'd1 ? CNT_W'(2) : CNT_W'(4);
    dec = ch.fiu_rsp_valid && (outstanding != '0);
    outstanding_nx = outstanding + (legal ? lines : '0) - (dec ? CNT_W'(1) : '0);
    drain_ack = state == DRAINED;
  end
  always_comb begin
    state_nx = state;
    case (state)
      RUN:      state_nx = drain_req ? DRAINING : RUN;
      DRAINING: state_nx = !drain_req ? RUN : outstanding == '0 ? DRAINED : DRAINING;
      DRAINED:  state_nx = drain_req ? DRAINED : RUN;
      default:  state_nx = RUN;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      outstanding <= '0;
      err_illegal_len <= 1'b0;
      err_underflow <= 1'b0;
      ch.fiu_rd_valid <= 1'b0;
      ch.fiu_rd_cl_len <= 2'd0;
      ch.fiu_rd_hdr <= '0;
    end else begin
      state <= state_nx;
      outstanding <= outstanding_nx;
      err_illegal_len <= err_illegal_len | illegal;
      err_underflow <= err_underflow | (ch.fiu_rsp_valid && outstanding == '0);
      ch.fiu_rd_valid <= legal;
      if (legal) begin
        ch.fiu_rd_cl_len <= ch.afu_rd_cl_len;
        ch.fiu_rd_hdr <= HDR_W'(ch.afu_rd_hdr);
      end
    end
  end
endmodule

// File: tb/tb_ofs_plat_host_chan_rd_throttle.sv
// tb_ofs_plat_host_chan_rd_throttle: directed bench with request scoreboard for the read throttle at an 8-line budget
module tb_ofs_plat_host_chan_rd_throttle;
  localparam int MAX = 8;
  localparam int HW = 128;
  localparam int CW = $clog2(MAX + 1);
  logic clk, reset, drain_req, drain_ack, err_illegal_len, err_underflow;
  logic [CW-1:0] outstanding;
  int checks = 0, errors = 0;
  logic [HW+1:0] sb[$];
  ofs_plat_host_chan_rd_throttle_if #(.HDR_W(HW)) ch ();
  ofs_plat_host_chan_rd_throttle #(.MAX_OUTSTANDING_LINES(MAX), .HDR_W(HW)) dut (
    .clk(clk), .reset(reset), .ch(ch), .drain_req(drain_req), .drain_ack(drain_ack),
    .outstanding(outstanding), .err_illegal_len(err_illegal_len), .err_underflow(err_underflow)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!reset && ch.fiu_rd_valid) begin
      logic [HW+1:0] e;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL fiu_unexpected observed %0h expected none", ch.fiu_rd_hdr);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        assert ({ch.fiu_rd_cl_len, ch.fiu_rd_hdr} === e) else begin
          errors++;
          $error("FAIL fiu_req observed %0h expected %0h", {ch.fiu_rd_cl_len, ch.fiu_rd_hdr}, e);
        end
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [1:0] cl, input logic [HW-1:0] h, input logic rsp, input logic exp_ready);
    ch.afu_rd_valid = 1'b1;
    ch.afu_rd_cl_len = cl;
    ch.afu_rd_hdr = h;
    ch.fiu_rsp_valid = rsp;
    #1;
    chk("afu_rd_ready", HW'(ch.afu_rd_ready), HW'(exp_ready));
    if (exp_ready && cl != 2'd2) sb.push_back({cl, h});
    cyc();
    ch.afu_rd_valid = 1'b0;
    ch.fiu_rsp_valid = 1'b0;
  endtask
  task automatic rsp(input int n);
    for (int i = 0; i < n; i++) begin
      ch.fiu_rsp_valid = 1'b1;
      cyc();
    end
    ch.fiu_rsp_valid = 1'b0;
    #1;
  endtask
  initial begin
    reset = 1'b1;
    drain_req = 1'b0;
    ch.afu_rd_valid = 1'b0;
    ch.afu_rd_cl_len = 2'd0;
    ch.afu_rd_hdr = '0;
    ch.fiu_almost_full = 1'b0;
    ch.fiu_rsp_valid = 1'b0;
    repeat (3) cyc();
    chk("rst_fiu_valid", HW'(ch.fiu_rd_valid), 0);
    chk("rst_fiu_cl_len", HW'(ch.fiu_rd_cl_len), 0);
    chk("rst_fiu_hdr", ch.fiu_rd_hdr, 0);
    chk("rst_outstanding", HW'(outstanding), 0);
    chk("rst_drain_ack", HW'(drain_ack), 0);
    chk("rst_errs", HW'({err_illegal_len, err_underflow}), 0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", HW'(ch.afu_rd_ready), 1);
    issue(2'd3, 128'hA5, 1'b0, 1'b1);
    chk("t1_fiu_valid", HW'(ch.fiu_rd_valid), 1);
    chk("t1_fiu_hdr", ch.fiu_rd_hdr, 128'hA5);
    chk("t1_outstanding", HW'(outstanding), 4);
    rsp(4);
    chk("t1_fiu_valid_drop", HW'(ch.fiu_rd_valid), 0);
    chk("t1_hdr_hold", ch.fiu_rd_hdr, 128'hA5);
    chk("t1_outstanding_0", HW'(outstanding), 0);
    chk("t1_no_errs", HW'({err_illegal_len, err_underflow}), 0);
    issue(2'd3, 128'hB1, 1'b0, 1'b1);
    issue(2'd3, 128'hB2, 1'b0, 1'b1);
    chk("t2_outstanding_8", HW'(outstanding), 8);
    issue(2'd3, 128'hB3, 1'b0, 1'b0);
    chk("t2_outstanding_held", HW'(outstanding), 8);
    rsp(1);
    chk("t2_outstanding_7", HW'(outstanding), 7);
    chk("t2_ready_7", HW'(ch.afu_rd_ready), 0);
    rsp(3);
    chk("t2_outstanding_4", HW'(outstanding), 4);
    chk("t2_ready_4", HW'(ch.afu_rd_ready), 1);
    issue(2'd1, 128'hC1, 1'b1, 1'b1);
    chk("t3_acc_rsp_5", HW'(outstanding), 5);
    rsp(1);
    issue(2'd3, 128'hC2, 1'b1, 1'b1);
    chk("t3_acc_rsp_7", HW'(outstanding), 7);
    rsp(7);
    chk("t3_outstanding_0", HW'(outstanding), 0);
    issue(2'd2, 128'hD1, 1'b0, 1'b1);
    chk("t4_no_fwd", HW'(ch.fiu_rd_valid), 0);
    chk("t4_hdr_hold", ch.fiu_rd_hdr, 128'hC2);
    chk("t4_outstanding", HW'(outstanding), 0);
    chk("t4_err_illegal", HW'(err_illegal_len), 1);
    cyc();
    chk("t4_err_illegal_sticky", HW'(err_illegal_len), 1);
    chk("t4_no_underflow", HW'(err_underflow), 0);
    rsp(1);
    chk("t5_err_underflow", HW'(err_underflow), 1);
    chk("t5_outstanding_0", HW'(outstanding), 0);
    issue(2'd1, 128'hE1, 1'b0, 1'b1);
    drain_req = 1'b1;
    issue(2'd0, 128'hE2, 1'b0, 1'b1);
    chk("t6_outstanding_3", HW'(outstanding), 3);
    chk("t6_ready_draining", HW'(ch.afu_rd_ready), 0);
    rsp(2);
    chk("t6_ack_pending", HW'(drain_ack), 0);
    rsp(1);
    chk("t6_outstanding_0", HW'(outstanding), 0);
    chk("t6_ack_not_yet", HW'(drain_ack), 0);
    cyc();
    chk("t6_drain_ack", HW'(drain_ack), 1);
    chk("t6_ready_drained", HW'(ch.afu_rd_ready), 0);
    drain_req = 1'b0;
    cyc();
    chk("t6_ack_drop", HW'(drain_ack), 0);
    chk("t6_ready_run", HW'(ch.afu_rd_ready), 1);
    ch.fiu_almost_full = 1'b1;
    #1;
    chk("t7_af_ready", HW'(ch.afu_rd_ready), 0);
    ch.fiu_almost_full = 1'b0;
    #1;
    chk("t7_af_release", HW'(ch.afu_rd_ready), 1);
    cyc();
    chk("sb_empty", HW'(sb.size()), 0);
    chk("errs_sticky", HW'({err_illegal_len, err_underflow}), 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
